oled_frame_streamer: RTL and testbench

SPI master for the 128x64 SSD1306 OLED. It powers up and resets the panel, then sends a fixed init command sequence. After that it streams the framebuffer forever. Pixel bytes are fetched from a registered pixel-source block over the pixelAddress/pixelData pull interface and shifted out MSB-first. It is the initiator end of the pixel interface that graph, text and LFSR demo tops respond to.

---
 rtl/oled_frame_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_oled_frame_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_frame_streamer.sv
//==============================================================================
// Module   : oled_frame_streamer
// Brief    : SSD1306 128x64 SPI master: panel reset, init ROM, endless framebuffer
//            stream pulled over pixelAddress/pixelData. Optional macro
//            OLED_FRAME_DONE_EN adds the frameDone pulse output.
// Revision : 1.0
//==============================================================================
`default_nettype none

module oled_frame_streamer #(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter logic [7:0]  CLK_DIV      = 8'd1,
    parameter logic [3:0]  FETCH_LAT    = 4'd2
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       ioSclk,
    output logic       ioSdin,
    output logic       ioCs,
    output logic       ioDc,
    output logic       ioReset,
    output logic [9:0] pixelAddress,
    input  logic [7:0] pixelData
`ifdef OLED_FRAME_DONE_EN
    ,
    output logic       frameDone
`endif
);

    typedef enum logic [2:0] {
        S_WAIT_PRE  = 3'd0,
        S_RST_LOW   = 3'd1,
        S_WAIT_POST = 3'd2,
        S_INIT_LOAD = 3'd3,
        S_SHIFT     = 3'd4,
        S_PIX_FETCH = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_wait_cnt;
    logic [7:0]  r_div_cnt;
    logic [3:0]  r_fetch_cnt;
    logic [2:0]  r_bit_cnt;
    logic [4:0]  r_cmd_idx;
    logic [7:0]  r_shift;
    logic [7:0]  w_rom_byte;

    assign ioSdin = r_shift[7];

    // Horizontal addressing (20 00) lets the panel wrap on its own each frame.
    always_comb begin
        w_rom_byte = 8'h00;
        case (r_cmd_idx)
            5'd0:  w_rom_byte = 8'hAE;
            5'd1:  w_rom_byte = 8'hD5;
            5'd2:  w_rom_byte = 8'h80;
            5'd3:  w_rom_byte = 8'hA8;
            5'd4:  w_rom_byte = 8'h3F;
            5'd5:  w_rom_byte = 8'hD3;
            5'd6:  w_rom_byte = 8'h00;
            5'd7:  w_rom_byte = 8'h40;
            5'd8:  w_rom_byte = 8'h8D;
            5'd9:  w_rom_byte = 8'h14;
            5'd10: w_rom_byte = 8'h20;
            5'd11: w_rom_byte = 8'h00;
            5'd12: w_rom_byte = 8'hA1;
            5'd13: w_rom_byte = 8'hC8;
            5'd14: w_rom_byte = 8'hDA;
            5'd15: w_rom_byte = 8'h12;
            5'd16: w_rom_byte = 8'h81;
            5'd17: w_rom_byte = 8'hCF;
            5'd18: w_rom_byte = 8'hD9;
            5'd19: w_rom_byte = 8'hF1;
            5'd20: w_rom_byte = 8'hDB;
            5'd21: w_rom_byte = 8'h40;
            5'd22: w_rom_byte = 8'hA4;
            5'd23: w_rom_byte = 8'hA6;
            5'd24: w_rom_byte = 8'hAF;
            default: w_rom_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_WAIT_PRE;
            r_wait_cnt   <= 32'd0;
            r_div_cnt    <= 8'd0;
            r_fetch_cnt  <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_cmd_idx    <= 5'd0;
            r_shift      <= 8'd0;
            ioSclk       <= 1'b0;
            ioCs         <= 1'b1;
            ioDc         <= 1'b0;
            ioReset      <= 1'b1;
            pixelAddress <= 10'd0;
`ifdef OLED_FRAME_DONE_EN
            frameDone    <= 1'b0;
`endif
        end else begin
`ifdef OLED_FRAME_DONE_EN
            frameDone <= 1'b0;
`endif
            case (r_state)
                S_WAIT_PRE: begin
                    if (r_wait_cnt == STARTUP_WAIT - 32'd1) begin
                        r_wait_cnt <= 32'd0;
                        ioReset    <= 1'b0;
                        r_state    <= S_RST_LOW;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_RST_LOW: begin
                    if (r_wait_cnt == STARTUP_WAIT - 32'd1) begin
                        r_wait_cnt <= 32'd0;
                        ioReset    <= 1'b1;
                        r_state    <= S_WAIT_POST;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_WAIT_POST: begin
                    // Chip select drops together with entry to the first load.
                    if (r_wait_cnt == STARTUP_WAIT - 32'd1) begin
                        r_wait_cnt <= 32'd0;
                        r_cmd_idx  <= 5'd0;
                        ioCs       <= 1'b0;
                        ioDc       <= 1'b0;
                        r_state    <= S_INIT_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_INIT_LOAD: begin
                    r_shift   <= w_rom_byte;
                    ioDc      <= 1'b0;
                    ioCs      <= 1'b0;
                    ioSclk    <= 1'b0;
                    r_bit_cnt <= 3'd0;
                    r_div_cnt <= 8'd0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div_cnt == CLK_DIV - 8'd1) begin
                        r_div_cnt <= 8'd0;
                        if (!ioSclk) begin
                            ioSclk <= 1'b1;
                        end else begin
                            ioSclk <= 1'b0;
                            if (r_bit_cnt == 3'd7) begin
                                r_fetch_cnt <= 4'd0;
                                if (!ioDc) begin
                                    if (r_cmd_idx == 5'd24) begin
                                        pixelAddress <= 10'd0;
                                        r_state      <= S_PIX_FETCH;
`ifdef OLED_FRAME_DONE_EN
                                        frameDone    <= 1'b1;
`endif
                                    end else begin
                                        r_cmd_idx <= r_cmd_idx + 5'd1;
                                        r_state   <= S_INIT_LOAD;
                                    end
                                end else begin
                                    pixelAddress <= pixelAddress + 10'd1;
                                    r_state      <= S_PIX_FETCH;
`ifdef OLED_FRAME_DONE_EN
                                    frameDone    <= (pixelAddress == 10'd1023);
`endif
                                end
                            end else begin
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_PIX_FETCH: begin
                    // Address has been stable FETCH_LAT cycles; the source has settled.
                    if (r_fetch_cnt == FETCH_LAT - 4'd1) begin
                        r_shift   <= pixelData;
                        ioDc      <= 1'b1;
                        r_bit_cnt <= 3'd0;
                        r_div_cnt <= 8'd0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_fetch_cnt <= r_fetch_cnt + 4'd1;
                    end
                end
                default: r_state <= S_WAIT_PRE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (CLK_DIV != 8'd0) else $error("oled_frame_streamer: CLK_DIV must be at least 1");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oled_frame_streamer.sv
// Scoreboard bench for oled_frame_streamer: startup timing, SPI byte decode,
// pixel streaming across a frame wrap, CLK_DIV=3 timing and mid-byte reset.
`timescale 1ns/1ps
`default_nettype none

module tb_oled_frame_streamer;

    logic       clk;
    logic       rstn;
    logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;
    logic [9:0] pixelAddress;
    logic [7:0] pixelData;
    logic       ioSclk3, ioSdin3, ioCs3, ioDc3, ioReset3;
    logic [9:0] pixelAddress3;
    logic [7:0] pixelData3;
`ifdef OLED_FRAME_DONE_EN
    logic       frameDone;
    logic       frameDone3;
    int         fd_total;
`endif

    int         checks;
    int         errors;
    int         mon_bits;
    logic [8:0] q[$];
    logic [7:0] c_rom [25];

    oled_frame_streamer #(.STARTUP_WAIT(32'd10), .CLK_DIV(8'd1), .FETCH_LAT(4'd2)) dut (
        .clk(clk), .rstn(rstn), .ioSclk(ioSclk), .ioSdin(ioSdin), .ioCs(ioCs),
        .ioDc(ioDc), .ioReset(ioReset), .pixelAddress(pixelAddress), .pixelData(pixelData)
`ifdef OLED_FRAME_DONE_EN
        , .frameDone(frameDone)
`endif
    );

    oled_frame_streamer #(.STARTUP_WAIT(32'd10), .CLK_DIV(8'd3), .FETCH_LAT(4'd2)) dut3 (
        .clk(clk), .rstn(rstn), .ioSclk(ioSclk3), .ioSdin(ioSdin3), .ioCs(ioCs3),
        .ioDc(ioDc3), .ioReset(ioReset3), .pixelAddress(pixelAddress3), .pixelData(pixelData3)
`ifdef OLED_FRAME_DONE_EN
        , .frameDone(frameDone3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered pixel source: one pipeline stage, data = low address byte.
    always @(posedge clk) begin
        pixelData  <= pixelAddress[7:0];
        pixelData3 <= pixelAddress3[7:0];
    end

    task automatic push_expected(input int n_data);
        for (int i = 0; i < 25; i++) q.push_back({1'b0, c_rom[i]});
        for (int i = 0; i < n_data; i++) q.push_back({1'b1, 8'(i)});
    endtask

    // Called at the negedge of cycle 0 (first period after the last reset edge).
    task automatic startup_check();
        logic er;
        logic ec;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            er = (k >= 10 && k < 20) ? 1'b0 : 1'b1;
            ec = (k < 30) ? 1'b1 : 1'b0;
            checks++;
            if (ioReset !== er || ioCs !== ec || ioReset3 !== er || ioCs3 !== ec) begin
                errors++;
                $display("FAIL startup cycle %0d: ioReset=%b ioCs=%b ioReset3=%b ioCs3=%b, required ioReset=%b ioCs=%b",
                         k, ioReset, ioCs, ioReset3, ioCs3, er, ec);
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bytes still pending after %0d cycles, required 0", q.size(), limit);
        end
    endtask

    // Monitor for the CLK_DIV=1 instance: decodes bytes on rising SCLK.
    initial begin : mon1
        logic       ps;
        logic [9:0] pa;
        logic [7:0] sh;
        logic       bdc;
        logic [8:0] exp_b;
        int         data_idx;
        int         cmd_cnt;
        int         cyc;
        int         last_fd;
        logic       fd_prev;
        ps = 1'b0; pa = 10'd0; sh = 8'd0; bdc = 1'b0;
        data_idx = 0; cmd_cnt = 0; cyc = 0; last_fd = -1; fd_prev = 1'b0;
        mon_bits = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ioCs) begin
                mon_bits = 0; data_idx = 0; cmd_cnt = 0; last_fd = -1;
            end else begin
                if (pixelAddress !== pa) begin
                    checks++;
                    if (mon_bits != 0 || pixelAddress !== pa + 10'd1) begin
                        errors++;
                        $display("FAIL addr_step: pixelAddress %0d -> %0d at bit %0d, required %0d at byte end",
                                 pa, pixelAddress, mon_bits, pa + 10'd1);
                    end
                end
                if (!ps && ioSclk) begin
                    if (mon_bits == 0) begin
                        bdc = ioDc;
                    end else begin
                        checks++;
                        if (ioDc !== bdc) begin
                            errors++;
                            $display("FAIL dc_stable: ioDc=%b mid-byte, required %b", ioDc, bdc);
                        end
                    end
                    sh = {sh[6:0], ioSdin};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        mon_bits = 0;
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL spi_byte: got dc=%b byte=%02h, required no byte", bdc, sh);
                        end else begin
                            exp_b = q.pop_front();
                            if ({bdc, sh} !== exp_b) begin
                                errors++;
                                $display("FAIL spi_byte: got dc=%b byte=%02h, required dc=%b byte=%02h",
                                         bdc, sh, exp_b[8], exp_b[7:0]);
                            end
                        end
                        if (bdc) begin
                            checks++;
                            if (pixelAddress !== 10'(data_idx)) begin
                                errors++;
                                $display("FAIL addr_byte: pixelAddress=%0d, required %0d", pixelAddress, data_idx % 1024);
                            end
                            data_idx++;
                        end else begin
                            cmd_cnt++;
                        end
                    end
                end
            end
`ifdef OLED_FRAME_DONE_EN
            if (frameDone === 1'b1) begin
                fd_total++;
                checks++;
                if (fd_prev) begin
                    errors++;
                    $display("FAIL frame_done_width: frameDone high 2 cycles, required 1");
                end
                checks++;
                if (last_fd < 0) begin
                    if (cmd_cnt != 25 || pixelAddress !== 10'd0) begin
                        errors++;
                        $display("FAIL frame_done_first: cmds=%0d addr=%0d, required cmds=25 addr=0", cmd_cnt, pixelAddress);
                    end
                end else if (cyc - last_fd != 1024 * 18) begin
                    errors++;
                    $display("FAIL frame_done_period: %0d cycles, required %0d", cyc - last_fd, 1024 * 18);
                end
                last_fd = cyc;
            end
            fd_prev = frameDone;
`endif
            ps = ioSclk;
            pa = pixelAddress;
        end
    end

    // Monitor for the CLK_DIV=3 instance: phase lengths and data-change timing.
    initial begin : mon3
        logic ps3;
        logic pd3;
        int   run;
        int   bits3;
        int   first_rise;
        int   cyc;
        ps3 = 1'b0; pd3 = 1'b0; run = 0; bits3 = 0; first_rise = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ioCs3) begin
                bits3 = 0;
                run = 0;
            end else begin
                if (ioSdin3 !== pd3) begin
                    checks++;
                    if (ioSclk3 !== 1'b0) begin
                        errors++;
                        $display("FAIL sdin_timing: ioSdin3 changed with ioSclk3=%b, required 0", ioSclk3);
                    end
                end
                if (ioSclk3 !== ps3) begin
                    if (ps3) begin
                        checks++;
                        if (run != 3) begin
                            errors++;
                            $display("FAIL sclk_high: high phase %0d clk, required 3", run);
                        end
                        if (bits3 == 8) begin
                            checks++;
                            if (cyc - first_rise != 45) begin
                                errors++;
                                $display("FAIL byte_len: first rise to end %0d clk, required 45", cyc - first_rise);
                            end
                            bits3 = 0;
                        end
                    end else begin
                        if (bits3 > 0) begin
                            checks++;
                            if (run != 3) begin
                                errors++;
                                $display("FAIL sclk_low: low phase %0d clk, required 3", run);
                            end
                        end else begin
                            first_rise = cyc;
                        end
                        bits3++;
                    end
                    run = 1;
                end else begin
                    run++;
                end
            end
            ps3 = ioSclk3;
            pd3 = ioSdin3;
        end
    end

    initial begin : stim
        int n;
        c_rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                  8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                  8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        checks = 0;
        errors = 0;
`ifdef OLED_FRAME_DONE_EN
        fd_total = 0;
`endif
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ioSclk !== 1'b0 || ioSdin !== 1'b0 || ioCs !== 1'b1 || ioDc !== 1'b0 ||
            ioReset !== 1'b1 || pixelAddress !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: sclk=%b sdin=%b cs=%b dc=%b rst=%b addr=%0d, required 0 0 1 0 1 0",
                     ioSclk, ioSdin, ioCs, ioDc, ioReset, pixelAddress);
        end
        rstn = 1'b1;
        push_expected(1028);
        startup_check();
        wait_drain(25000);

        n = 0;
        while (!(mon_bits == 4 && ioDc === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL bit4_wait: bit 4 of a data byte not seen in 200 cycles, required it");
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (ioCs !== 1'b1 || ioSclk !== 1'b0 || pixelAddress !== 10'd0 || ioReset !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: cs=%b sclk=%b addr=%0d rst=%b, required 1 0 0 1",
                     ioCs, ioSclk, pixelAddress, ioReset);
        end
        q.delete();
        push_expected(3);
        rstn = 1'b1;
        startup_check();
        wait_drain(1500);
`ifdef OLED_FRAME_DONE_EN
        checks++;
        if (fd_total != 3) begin
            errors++;
            $display("FAIL frame_done_count: %0d pulses, required 3", fd_total);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
